// File: rtl/inst_buffer_ctrl_pkg.sv
// Shared types for the instruction buffer: fetch packet layout, WFI encoding, sequencer states.
// Optional feature macro used by the top: INST_BUF_BYPASS_EN.
`ifndef INST_BUFFER_CTRL_PKG_DEFS
`define INST_BUFFER_CTRL_PKG_DEFS
`define WFI   32'h10500073
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package inst_buffer_ctrl_pkg;

    localparam int unsigned IBUF_DEPTH = 8;
    localparam int unsigned XLEN       = 32;
    localparam logic [XLEN-1:0] WFI_INST = `WFI;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
        logic            valid;
    } FETCH_PACKET;

    typedef enum logic [1:0] {
        IBUF_RUN,
        IBUF_HALT_PEND,
        IBUF_HALTED
    } IBUF_STATE;

endpackage

// File: rtl/inst_buffer_ctrl_fifo_mem.sv
// Storage array for the instruction buffer: one write port, one asynchronous read port.
// Data is not reset; validity is tracked by the parent's count.
module ibuf_fifo_mem
    import inst_buffer_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = IBUF_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  FETCH_PACKET       wdata,
    input  logic [PTR_W-1:0]  raddr,
    output FETCH_PACKET       rdata
);

    FETCH_PACKET mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_buffer_ctrl.sv
// Instruction buffer and sequencer between fetch and decode/dispatch, with WFI halt and squash.
// Define INST_BUF_BYPASS_EN to let a packet flow straight through an empty buffer.
module inst_buffer_ctrl
    import inst_buffer_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = IBUF_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            squash,
    input  logic            fetch_valid,
    input  FETCH_PACKET     fetch_packet,
    output logic            fetch_ready,
    input  logic            disp_ready,
    output logic            disp_valid,
    output FETCH_PACKET     disp_packet,
    output logic [PTR_W:0]  count,
    output logic            halted
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] halt_pend_ptr;
    IBUF_STATE        state;
    FETCH_PACKET      rd_data;
    logic             buf_valid;
    logic             bypass;
    logic             push;
    logic             pop;
    logic             is_wfi;

    ibuf_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (tail),
        .wdata (fetch_packet),
        .raddr (head),
        .rdata (rd_data)
    );

    // fetch_ready depends only on state, count and squash: no path from disp_ready
    assign fetch_ready = (count < CNT_W'(DEPTH)) && (state == IBUF_RUN) && !squash;
    assign buf_valid   = (count != '0) && (state != IBUF_HALTED);
    assign is_wfi      = (fetch_packet.inst == WFI_INST);

`ifdef INST_BUF_BYPASS_EN
    assign bypass = (count == '0) && (state == IBUF_RUN) && !squash &&
                    fetch_valid && fetch_packet.valid && disp_ready;
`else
    assign bypass = 1'b0;
`endif

    assign push = fetch_valid && fetch_ready && fetch_packet.valid && !bypass;
    assign pop  = buf_valid && disp_ready && !squash;

    assign disp_valid  = buf_valid || bypass;
    assign disp_packet = bypass           ? fetch_packet :
                         (count == '0)    ? '0           : rd_data;

    // Pointers, occupancy and halt sequencing; squash overrides everything
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            halt_pend_ptr <= '0;
            state         <= IBUF_RUN;
            halted        <= 1'b0;
        end else if (squash) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            halt_pend_ptr <= '0;
            state         <= IBUF_RUN;
            halted        <= 1'b0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            case (state)
                IBUF_RUN: begin
                    if (push && is_wfi) begin
                        halt_pend_ptr <= tail;
                        state         <= IBUF_HALT_PEND;
                    end else if (bypass && is_wfi) begin
                        state  <= IBUF_HALTED;
                        halted <= 1'b1;
                    end
                end
                IBUF_HALT_PEND: begin
                    if (pop && (head == halt_pend_ptr)) begin
                        state  <= IBUF_HALTED;
                        halted <= 1'b1;
                    end
                end
                IBUF_HALTED: begin
                    state <= IBUF_HALTED;
                end
                default: begin
                    state  <= IBUF_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_buffer_ctrl.sv
// Directed-vector bench for inst_buffer_ctrl: fill/drain, streaming wrap, WFI halt, squash, reset.
module tb_inst_buffer_ctrl;
    import inst_buffer_ctrl_pkg::*;

    localparam logic [31:0] ADD_INST = 32'h002081b3;

    logic        clock;
    logic        reset_n;
    logic        squash;
    logic        fetch_valid;
    FETCH_PACKET fetch_packet;
    logic        fetch_ready;
    logic        disp_ready;
    logic        disp_valid;
    FETCH_PACKET disp_packet;
    logic [3:0]  count;
    logic        halted;

    int n_vec;
    int n_err;

    inst_buffer_ctrl #(.DEPTH(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .squash       (squash),
        .fetch_valid  (fetch_valid),
        .fetch_packet (fetch_packet),
        .fetch_ready  (fetch_ready),
        .disp_ready   (disp_ready),
        .disp_valid   (disp_valid),
        .disp_packet  (disp_packet),
        .count        (count),
        .halted       (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic FETCH_PACKET mk(input logic [31:0] pc, input logic [31:0] inst);
        FETCH_PACKET p;
        p.inst  = inst;
        p.pc    = pc;
        p.npc   = pc + 32'd4;
        p.valid = 1'b1;
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset_n      = 1'b0;
        squash       = 1'b0;
        fetch_valid  = 1'b0;
        fetch_packet = '0;
        disp_ready   = 1'b0;

        #3;
        check("rst_count",  128'(count), 128'd0);
        check("rst_dvalid", 128'(disp_valid), 128'd0);
        check("rst_fready", 128'(fetch_ready), 128'd1);
        check("rst_halted", 128'(halted), 128'd0);
        check("rst_dpkt",   128'(disp_packet), 128'd0);
        #9 reset_n = 1'b1;
        tick();

        // Fill eight entries with dispatch stalled
        for (int i = 0; i < 8; i++) begin
            fetch_valid  = 1'b1;
            fetch_packet = mk(32'(4 * i), ADD_INST);
            #1;
            check("fill_fready", 128'(fetch_ready), 128'd1);
            tick();
        end
        fetch_valid = 1'b0;
        #1;
        check("full_count",  128'(count), 128'd8);
        check("full_fready", 128'(fetch_ready), 128'd0);
        check("full_dvalid", 128'(disp_valid), 128'd1);

        // Drain in order
        disp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("drain_pc",    128'(disp_packet.pc), 128'(4 * i));
            check("drain_count", 128'(count), 128'(8 - i));
            tick();
        end
        disp_ready = 1'b0;
        #1;
        check("empty_count",  128'(count), 128'd0);
        check("empty_dvalid", 128'(disp_valid), 128'd0);
        check("empty_dpkt",   128'(disp_packet), 128'd0);

        // Stream at count=3 across the pointer wrap
        for (int i = 0; i < 3; i++) begin
            fetch_valid  = 1'b1;
            fetch_packet = mk(32'h200 + 32'(4 * i), ADD_INST);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            fetch_valid  = 1'b1;
            fetch_packet = mk(32'h20c + 32'(4 * k), ADD_INST);
            disp_ready   = 1'b1;
            #1;
            check("stream_pc",    128'(disp_packet.pc), 128'(32'h200 + 32'(4 * k)));
            check("stream_count", 128'(count), 128'd3);
            tick();
        end
        fetch_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stream_tail_pc", 128'(disp_packet.pc), 128'(32'h250 + 32'(4 * i)));
            tick();
        end
        disp_ready = 1'b0;
        #1;
        check("stream_empty", 128'(count), 128'd0);

        // WFI halt sequence
        fetch_valid = 1'b1;
        fetch_packet = mk(32'h300, ADD_INST); tick();
        fetch_packet = mk(32'h304, ADD_INST); tick();
        fetch_packet = mk(32'h308, WFI_INST); tick();
        fetch_packet = mk(32'h30c, ADD_INST);
        #1;
        check("wfi_fready", 128'(fetch_ready), 128'd0);
        tick();
        check("wfi_count_noack", 128'(count), 128'd3);
        fetch_valid = 1'b0;
        disp_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wfi_pop_pc",  128'(disp_packet.pc), 128'(32'h300 + 32'(4 * i)));
            check("wfi_pop_hlt", 128'(halted), 128'd0);
            tick();
        end
        fetch_valid  = 1'b1;
        fetch_packet = mk(32'h310, ADD_INST);
        for (int i = 0; i < 12; i++) begin
            #1;
            check("halt_hold",   128'(halted), 128'd1);
            check("halt_dvalid", 128'(disp_valid), 128'd0);
            check("halt_fready", 128'(fetch_ready), 128'd0);
            tick();
        end
        check("halt_count", 128'(count), 128'd0);
        fetch_valid = 1'b0;
        disp_ready  = 1'b0;
        squash      = 1'b1;
        tick();
        squash = 1'b0;
        #1;
        check("unhalt_halted", 128'(halted), 128'd0);
        check("unhalt_fready", 128'(fetch_ready), 128'd1);

        // Squash with five entries and a concurrent push/pop
        fetch_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_packet = mk(32'h400 + 32'(4 * i), ADD_INST);
            tick();
        end
        check("sq_pre_count", 128'(count), 128'd5);
        fetch_packet = mk(32'h500, ADD_INST);
        disp_ready   = 1'b1;
        squash       = 1'b1;
        #1;
        check("sq_fready", 128'(fetch_ready), 128'd0);
        tick();
        squash      = 1'b0;
        fetch_valid = 1'b0;
        disp_ready  = 1'b0;
        #1;
        check("sq_count",  128'(count), 128'd0);
        check("sq_dvalid", 128'(disp_valid), 128'd0);
        check("sq_halted", 128'(halted), 128'd0);
        check("sq_fready_after", 128'(fetch_ready), 128'd1);
        fetch_valid  = 1'b1;
        fetch_packet = mk(32'h100, ADD_INST);
        tick();
        fetch_valid = 1'b0;
        #1;
        check("sq_next_dvalid", 128'(disp_valid), 128'd1);
        check("sq_next_pc",     128'(disp_packet.pc), 128'h100);
        check("sq_next_count",  128'(count), 128'd1);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        check("sq_drained", 128'(count), 128'd0);

        // Invalid packet is acked but not stored
        fetch_valid  = 1'b1;
        fetch_packet = mk(32'h600, ADD_INST);
        fetch_packet.valid = 1'b0;
        disp_ready   = 1'b1;
        #1;
        check("inv_fready", 128'(fetch_ready), 128'd1);
        check("inv_dvalid", 128'(disp_valid), 128'd0);
        tick();
        fetch_valid = 1'b0;
        disp_ready  = 1'b0;
        #1;
        check("inv_count",        128'(count), 128'd0);
        check("inv_dvalid_after", 128'(disp_valid), 128'd0);

        // Async reset mid-cycle while in HALT_PEND with four entries
        fetch_valid = 1'b1;
        fetch_packet = mk(32'h700, ADD_INST); tick();
        fetch_packet = mk(32'h704, ADD_INST); tick();
        fetch_packet = mk(32'h708, ADD_INST); tick();
        fetch_packet = mk(32'h70c, WFI_INST); tick();
        fetch_valid = 1'b0;
        check("hp_count",  128'(count), 128'd4);
        check("hp_fready", 128'(fetch_ready), 128'd0);
        #1 reset_n = 1'b0;
        #1;
        check("ar_count",  128'(count), 128'd0);
        check("ar_dvalid", 128'(disp_valid), 128'd0);
        check("ar_halted", 128'(halted), 128'd0);
        check("ar_fready", 128'(fetch_ready), 128'd1);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        fetch_valid  = 1'b1;
        fetch_packet = mk(32'h800, ADD_INST);
        disp_ready   = 1'b1;
        #1;
`ifdef INST_BUF_BYPASS_EN
        check("byp_dvalid", 128'(disp_valid), 128'd1);
        check("byp_pc",     128'(disp_packet.pc), 128'h800);
        tick();
        fetch_valid = 1'b0;
        disp_ready  = 1'b0;
        check("byp_count", 128'(count), 128'd0);
`else
        check("lat_dvalid_same", 128'(disp_valid), 128'd0);
        tick();
        fetch_valid = 1'b0;
        disp_ready  = 1'b0;
        #1;
        check("lat_dvalid_next", 128'(disp_valid), 128'd1);
        check("lat_pc",          128'(disp_packet.pc), 128'h800);
        check("lat_count",       128'(count), 128'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
